// File: rtl/fbindct_bram_wr_ctrl.sv
// fbindct_bram_wr_ctrl
// Output-side ping-pong BRAM writer for the forward binDCT datapath.
// Each accepted coefficient row is split into DATA_WIDTH words and written
// into partition A (base 0) or B (base DATA_DEPTH). After ROW_DIM rows the PS
// interrupt line toggles and ps_part reports the finished partition.
// A partition is reused only after the PS has dropped and re-raised its
// free flag.
// Optional feature: define FBINDCT_WR_SAT_EN to clamp every lane to the
// signed SAT_BITS range before it is captured.
module fbindct_bram_wr_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_DEPTH = 512,
    parameter int ROW_DIM    = 8,
    parameter int COEF_WIDTH = 16,
    parameter int SAT_BITS   = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       ps_gpio,
    output logic                             ps_irq,
    output logic                             ps_part,
    output logic [ADDR_WIDTH-1:0]            bram_addr,
    output logic [DATA_WIDTH-1:0]            bram_wrdata,
    output logic                             bram_en,
    output logic [DATA_WIDTH/8-1:0]          bram_we,
    input  logic                             coef_valid,
    output logic                             coef_ready,
    input  logic [ROW_DIM*COEF_WIDTH-1:0]    coef_row,
    output logic                             busy
);

    localparam int ROW_BITS = ROW_DIM * COEF_WIDTH;
    localparam int WPR      = ROW_BITS / DATA_WIDTH;
    localparam int WE_W     = DATA_WIDTH / 8;
    localparam int RC_W     = (ROW_DIM > 1) ? $clog2(ROW_DIM) : 1;
    localparam int WI_W     = $clog2(WPR + 1);

    // Reject configurations the word split or the clamp cannot handle.
    if (((ROW_BITS % DATA_WIDTH) != 0) || (SAT_BITS < 2) || (SAT_BITS > COEF_WIDTH)) begin : g_bad_cfg
        $error("fbindct_bram_wr_ctrl: unsupported parameter combination");
    end

`ifdef FBINDCT_WR_SAT_EN
    localparam logic signed [COEF_WIDTH-1:0] SAT_MAX = COEF_WIDTH'((1 << (SAT_BITS - 1)) - 1);
    localparam logic signed [COEF_WIDTH-1:0] SAT_MIN = COEF_WIDTH'(-(1 << (SAT_BITS - 1)));
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Lane conditioning applied to a row before it is captured.
    function automatic logic [ROW_BITS-1:0] condition_row(input logic [ROW_BITS-1:0] row);
        logic [ROW_BITS-1:0] res;
`ifdef FBINDCT_WR_SAT_EN
        logic signed [COEF_WIDTH-1:0] lane;
`endif
        res = row;
`ifdef FBINDCT_WR_SAT_EN
        for (int k = 0; k < ROW_DIM; k++) begin
            lane = row[k*COEF_WIDTH +: COEF_WIDTH];
            if (lane > SAT_MAX) begin
                res[k*COEF_WIDTH +: COEF_WIDTH] = SAT_MAX;
            end else if (lane < SAT_MIN) begin
                res[k*COEF_WIDTH +: COEF_WIDTH] = SAT_MIN;
            end else begin
                res[k*COEF_WIDTH +: COEF_WIDTH] = lane;
            end
        end
`endif
        return res;
    endfunction

    // Word address inside the selected partition; no wrap protection needed
    // because a full block always fits into one partition.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic part,
                                                        input logic [RC_W-1:0] row,
                                                        input logic [WI_W-1:0] idx);
        logic [ADDR_WIDTH-1:0] base;
        base = part ? ADDR_WIDTH'(DATA_DEPTH) : {ADDR_WIDTH{1'b0}};
        return base + (ADDR_WIDTH'(row) * ADDR_WIDTH'(WPR)) + ADDR_WIDTH'(idx);
    endfunction

    state_t                  state_r, state_s;
    logic                    last_r, last_s;
    logic                    cur_r, cur_s;
    logic [1:0]              used_r, used_s;
    logic [RC_W-1:0]         row_cnt_r, row_cnt_s;
    logic [WI_W-1:0]         word_idx_r, word_idx_s;
    logic [ROW_BITS-1:0]     row_r, row_s;
    logic [ROW_BITS-1:0]     cap_row_s;
    logic                    target_s;
    logic                    ps_irq_r, ps_irq_s;
    logic                    ps_part_r, ps_part_s;
    logic [ADDR_WIDTH-1:0]   bram_addr_r, bram_addr_s;
    logic [DATA_WIDTH-1:0]   bram_wrdata_r, bram_wrdata_s;
    logic                    bram_en_r, bram_en_s;
    logic [WE_W-1:0]         bram_we_r, bram_we_s;
    logic                    coef_ready_r, coef_ready_s;
    logic                    busy_r, busy_s;

    // Next-state and next-output computation for the writer FSM.
    always_comb begin
        state_s       = state_r;
        last_s        = last_r;
        cur_s         = cur_r;
        used_s        = used_r & ps_gpio;
        row_cnt_s     = row_cnt_r;
        word_idx_s    = word_idx_r;
        row_s         = row_r;
        ps_irq_s      = ps_irq_r;
        ps_part_s     = ps_part_r;
        bram_addr_s   = bram_addr_r;
        bram_wrdata_s = bram_wrdata_r;
        bram_en_s     = 1'b0;
        target_s      = ~last_r;
        cap_row_s     = condition_row(coef_row);

        case (state_r)
            ST_IDLE: begin
                if (ps_gpio[target_s] && !used_r[target_s]) begin
                    cur_s     = target_s;
                    row_cnt_s = {RC_W{1'b0}};
                    state_s   = ST_WAIT_ROW;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_WAIT_ROW: begin
                if (coef_valid && coef_ready_r) begin
                    row_s         = cap_row_s;
                    bram_addr_s   = word_addr(cur_r, row_cnt_r, {WI_W{1'b0}});
                    bram_wrdata_s = cap_row_s[DATA_WIDTH-1:0];
                    bram_en_s     = 1'b1;
                    word_idx_s    = WI_W'(1);
                    state_s       = ST_WRITE;
                end else begin
                    state_s       = ST_WAIT_ROW;
                end
            end
            ST_WRITE: begin
                if (word_idx_r == WI_W'(WPR)) begin
                    word_idx_s = {WI_W{1'b0}};
                    if (row_cnt_r == RC_W'(ROW_DIM - 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        row_cnt_s = row_cnt_r + RC_W'(1);
                        state_s   = ST_WAIT_ROW;
                    end
                end else begin
                    bram_addr_s   = word_addr(cur_r, row_cnt_r, word_idx_r);
                    bram_wrdata_s = row_r[int'(word_idx_r)*DATA_WIDTH +: DATA_WIDTH];
                    bram_en_s     = 1'b1;
                    word_idx_s    = word_idx_r + WI_W'(1);
                end
            end
            ST_DONE: begin
                ps_irq_s       = ~ps_irq_r;
                ps_part_s      = cur_r;
                used_s[cur_r]  = 1'b1;
                last_s         = cur_r;
                state_s        = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        bram_we_s    = bram_en_s ? {WE_W{1'b1}} : {WE_W{1'b0}};
        coef_ready_s = (state_s == ST_WAIT_ROW);
        busy_s       = (state_s != ST_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_r        <= 1'b1;
            cur_r         <= 1'b0;
            used_r        <= 2'b00;
            row_cnt_r     <= {RC_W{1'b0}};
            word_idx_r    <= {WI_W{1'b0}};
            row_r         <= {ROW_BITS{1'b0}};
            ps_irq_r      <= 1'b0;
            ps_part_r     <= 1'b0;
            bram_addr_r   <= {ADDR_WIDTH{1'b0}};
            bram_wrdata_r <= {DATA_WIDTH{1'b0}};
            bram_en_r     <= 1'b0;
            bram_we_r     <= {WE_W{1'b0}};
            coef_ready_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            last_r        <= last_s;
            cur_r         <= cur_s;
            used_r        <= used_s;
            row_cnt_r     <= row_cnt_s;
            word_idx_r    <= word_idx_s;
            row_r         <= row_s;
            ps_irq_r      <= ps_irq_s;
            ps_part_r     <= ps_part_s;
            bram_addr_r   <= bram_addr_s;
            bram_wrdata_r <= bram_wrdata_s;
            bram_en_r     <= bram_en_s;
            bram_we_r     <= bram_we_s;
            coef_ready_r  <= coef_ready_s;
            busy_r        <= busy_s;
        end
    end

    assign ps_irq      = ps_irq_r;
    assign ps_part     = ps_part_r;
    assign bram_addr   = bram_addr_r;
    assign bram_wrdata = bram_wrdata_r;
    assign bram_en     = bram_en_r;
    assign bram_we     = bram_we_r;
    assign coef_ready  = coef_ready_r;
    assign busy        = busy_r;

endmodule

// File: doc/fbindct_bram_wr_ctrl.md
Name: fbindct_bram_wr_ctrl

Overview:
- Output-side ping-pong BRAM writer for the forward binDCT datapath.
- Accepts one transformed row of ROW_DIM coefficients per valid/ready handshake and splits it into DATA_WIDTH words.
- Writes the words into partition A or B of the result BRAM, and toggles a PS interrupt after each block of ROW_DIM rows.
- The PS drains the finished partition and returns it with a per-partition free flag.

Parameters:
- DATA_WIDTH, 32, BRAM word width.
- ADDR_WIDTH, 13, BRAM word address width.
- DATA_DEPTH, 512, words per partition; A base = 0, B base = DATA_DEPTH.
- ROW_DIM, 8, coefficients per row and rows per block.
- COEF_WIDTH, 16, signed coefficient width; ROW_DIM*COEF_WIDTH must be a multiple of DATA_WIDTH.
- SAT_BITS, 12, saturation width, used only with FBINDCT_WR_SAT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ps_gpio  in  2  [0] = partition A free, [1] = partition B free (set by PS).
- ps_irq  out  1  toggles once per completed block; PS detects both edges.
- ps_part  out  1  partition just completed (0 = A, 1 = B); valid when ps_irq toggles.
- bram_addr  out  ADDR_WIDTH  write address.
- bram_wrdata  out  DATA_WIDTH  write data.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_WIDTH/8  byte write enables.
- coef_valid  in  1  row available from DCT.
- coef_ready  out  1  writer can accept a row.
- coef_row  in  ROW_DIM*COEF_WIDTH  coefficient row; lane k = bits [k*COEF_WIDTH +: COEF_WIDTH].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is rst, synchronous and active-high; clock is clk.
- Reset values:
  - ps_irq = 0, ps_part = 0.
  - bram_en = 0, bram_we = 0, bram_addr = 0, bram_wrdata = 0.
  - coef_ready = 0, busy = 0.
  - Internal: last = B, so the first block goes to A; used[1:0] = 0; row_cnt = 0; word_idx = 0.
- Derived constants:
  - WPR = ROW_DIM*COEF_WIDTH/DATA_WIDTH (4 at defaults).
  - Word i of a row = captured row bits [i*DATA_WIDTH +: DATA_WIDTH].
  - Address = base + row_cnt*WPR + i. Address arithmetic is ADDR_WIDTH wide with no wrap check; ROW_DIM*WPR <= DATA_DEPTH is required.
- State machine:
  - IDLE:
    - Target partition = ~last.
    - Enter when target free flag = 1 and used[target] = 0: set cur = target, row_cnt = 0, go to WAIT_ROW.
    - Otherwise stay in IDLE; the opposite partition is never taken out of order.
  - WAIT_ROW:
    - coef_ready = 1.
    - On coef_valid & coef_ready (cycle T): capture coef_row into a row register (after saturation if enabled), go to WRITE.
  - WRITE:
    - Cycles T+1 .. T+WPR, one word per cycle: bram_en = 1, bram_we = all ones.
    - After the last word: if row_cnt == ROW_DIM-1 go to DONE, else row_cnt += 1 and return to WAIT_ROW. coef_ready is high again at T+WPR+1.
  - DONE (one cycle):
    - ps_irq <= ~ps_irq, ps_part <= cur.
    - used[cur] <= 1, last <= cur.
    - bram_en = bram_we = 0. Go to IDLE.
- Ownership handshake:
  - used[p] clears in any cycle where ps_gpio[p] == 0.
  - A partition is therefore reused only after the PS has dropped and re-raised its free flag. This prevents overwriting a stale-high flag just after the IRQ.
- coef_ready = 0 in IDLE, WRITE and DONE. A row offered in those states is held by upstream, not dropped.
- bram_en and bram_we are 0 outside WRITE; bram_addr and bram_wrdata hold their last values.
- A free flag dropping mid-block is ignored; the block in progress completes.
- Reset mid-block: state returns to IDLE and the partial block is abandoned. No IRQ is sent; next target is A.
- Simultaneous used-set (DONE) and ps_gpio low in the same cycle: set wins.

Optional Feature:
- Macro: FBINDCT_WR_SAT_EN.
- With the macro: each lane is clamped to the signed SAT_BITS range (-2^(SAT_BITS-1) .. 2^(SAT_BITS-1)-1), then sign-extended back to COEF_WIDTH before capture.
- Without the macro: lanes are stored unmodified. The SAT_BITS parameter is unused.

Test Plan:
- Reset, ps_gpio = 01, then 8 rows with lane k of row r = r*16+k -> 32 writes to addr 0..31, word 0 of row 0 = 0x00010000; ps_irq 0->1, ps_part = 0.
- Continue with ps_gpio = 11 -> second block written to addr 512..543; ps_irq 1->0, ps_part = 1. While ps_gpio[0] stays high, no third block starts until gpio[0] goes 0 then 1.
- Hold coef_valid high continuously -> coef_ready pulses with period WPR+1 = 5 cycles and exactly one row is captured per pulse.
- ps_gpio = 10 after reset -> stays in IDLE with coef_ready = 0 and busy = 0, because B is not taken first.
- Assert rst after 3 rows of a block -> all outputs return to reset values, no ps_irq toggle; the next block starts at addr 0.
- With FBINDCT_WR_SAT_EN and SAT_BITS = 12: lanes 0x7FFF and 0x8000 are stored as 0x07FF and 0xF800. Without the macro they are stored as 0x7FFF and 0x8000.
